// File: rtl/reservoir_stream.sv
// Time-multiplexed delayed-feedback reservoir: each accepted sample becomes one virtual node
// x = NL(sat(din + (x_prev_frame >>> fb_shift))), streamed out through one output register.
module reservoir_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int MAX_NODES  = 64,
    parameter int NL_MODE    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stop,
    input  logic [$clog2(MAX_NODES+1)-1:0]     cfg_num_nodes,
    input  logic [$clog2(DATA_WIDTH)-1:0]      cfg_fb_shift,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               din_valid,
    output logic                               din_ready,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               dout_valid,
    input  logic                               dout_ready,
    output logic [$clog2(MAX_NODES)-1:0]       dout_node,
    output logic                               dout_last,
    output logic                               busy
);
    localparam int NW = $clog2(MAX_NODES + 1);
    localparam int IW = $clog2(MAX_NODES);
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [NW-1:0] MAX_N = NW'(MAX_NODES);
    localparam logic [NW-1:0] ONE_N = NW'(1);
    localparam logic [IW-1:0] ONE_I = IW'(1);
    localparam logic signed [DATA_WIDTH-1:0] NL_HI = DATA_WIDTH'(2 ** FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] NL_LO = -NL_HI;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // Overflow of the one-bit-wider sum shows as a disagreement of its top two bits.
    function automatic logic [DATA_WIDTH-1:0] sat_fn(input logic [DATA_WIDTH:0] s);
        logic [DATA_WIDTH-1:0] r;
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) r = {s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}};
        else r = s[DATA_WIDTH-1:0];
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] clamp_fn(input logic signed [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v > NL_HI) r = NL_HI;
        else if (v < NL_LO) r = NL_LO;
        else r = v;
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [NW-1:0]           n_q, n_d;
    logic [SW-1:0]           shift_q, shift_d;
    logic [IW-1:0]           wp_q, wp_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [IW-1:0]           node_q, node_d;
    logic                    last_q, last_d;

    logic signed [DATA_WIDTH-1:0] mem [MAX_NODES];

    logic                    wp_last_s;
    logic [IW-1:0]           wp_inc_s;
    logic signed [DATA_WIDTH-1:0] fb_s;
    logic [DATA_WIDTH:0]     sum_s;
    logic [DATA_WIDTH-1:0]   sat_s;
    logic [DATA_WIDTH-1:0]   x_s;
    logic                    din_ready_s;
    logic                    accept_s;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            n_q          <= MAX_N;
            shift_q      <= {SW{1'b0}};
            wp_q         <= {IW{1'b0}};
            dout_q       <= {DATA_WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            node_q       <= {IW{1'b0}};
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            wp_q         <= wp_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            node_q       <= node_d;
            last_q       <= last_d;
        end
    end

    // Node delay memory, deliberately unreset: the CLEAR pass zeroes the active entries
    always_ff @(posedge clk) begin
        if (mem_we_s) mem[wp_q] <= mem_wdata_s;
    end

    // Node datapath: feedback from the same node one frame ago
    always_comb begin
        wp_last_s = (NW'(wp_q) == (n_q - ONE_N));
        wp_inc_s  = wp_last_s ? {IW{1'b0}} : (wp_q + ONE_I);
        fb_s      = mem[wp_q] >>> shift_q;
        sum_s     = {din[DATA_WIDTH-1], din} + {fb_s[DATA_WIDTH-1], fb_s};
        sat_s     = sat_fn(sum_s);
        if (NL_MODE == 1) x_s = clamp_fn($signed(sat_s));
        else x_s = sat_s;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        shift_d = shift_q;
        wp_d    = wp_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    n_d     = (cfg_num_nodes == {NW{1'b0}} || cfg_num_nodes > MAX_N) ? MAX_N : cfg_num_nodes;
                    shift_d = cfg_fb_shift;
                    wp_d    = {IW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (wp_last_s) state_d = S_RUN;
                else state_d = S_CLEAR;
                wp_d = wp_inc_s;
            end
            S_RUN: begin
                if (stop) state_d = S_DRAIN;
                else state_d = S_RUN;
                if (accept_s) wp_d = wp_inc_s;
                else wp_d = wp_q;
            end
            S_DRAIN: begin
                if (!dout_valid_q) state_d = S_IDLE;
                else state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake, memory write and output register next values
    always_comb begin
        din_ready_s  = (state_q == S_RUN) && (!dout_valid_q || dout_ready);
        accept_s     = din_ready_s && din_valid;
        mem_we_s     = 1'b0;
        mem_wdata_s  = {DATA_WIDTH{1'b0}};
        dout_d       = dout_q;
        node_d       = node_q;
        last_d       = last_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        if (state_q == S_CLEAR) begin
            mem_we_s = 1'b1;
        end else if (accept_s) begin
            mem_we_s     = 1'b1;
            mem_wdata_s  = x_s;
            dout_d       = x_s;
            node_d       = wp_q;
            last_d       = wp_last_s;
            dout_valid_d = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    assign din_ready  = din_ready_s;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_node  = node_q;
    assign dout_last  = last_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_reservoir_stream.sv
// Self-checking bench for reservoir_stream: directed scenarios plus randomized traffic,
// both checked every cycle against a frame-level reference model (saturating and hard-tanh variants).
module tb_reservoir_stream;
    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int MAXN = 8;
    localparam int NW   = $clog2(MAXN + 1);
    localparam int IW   = $clog2(MAXN);
    localparam int SW   = $clog2(W);

    logic clk = 1'b0;
    logic rst, start, stop, din_valid, dout_ready;
    logic [NW-1:0] cfg_num_nodes;
    logic [SW-1:0] cfg_fb_shift;
    logic [W-1:0]  din;
    logic          din_ready0, dout_valid0, dout_last0, busy0;
    logic          din_ready1, dout_valid1, dout_last1, busy1;
    logic [W-1:0]  dout0, dout1;
    logic [IW-1:0] dout_node0, dout_node1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_mode;      // 0 idle, 1 clearing, 2 running, 3 draining
    int          m_n, m_sh, m_clr, m_pos;
    int          prev0 [MAXN];
    int          prev1 [MAXN];
    bit          e_valid, e_last;
    logic [W-1:0] e_dout0, e_dout1;
    int          e_node;
    bit          last_acc, obs_rdy;

    logic [W-1:0] stim_q[$];
    logic [W-1:0] cap0_q[$];
    logic [W-1:0] cap1_q[$];
    int           capn_q[$];
    bit           capl_q[$];

    always #5 clk = ~clk;

    reservoir_stream #(.DATA_WIDTH(W), .FRAC_BITS(FRAC), .MAX_NODES(MAXN), .NL_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_num_nodes(cfg_num_nodes), .cfg_fb_shift(cfg_fb_shift),
        .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
        .dout_node(dout_node0), .dout_last(dout_last0), .busy(busy0)
    );

    reservoir_stream #(.DATA_WIDTH(W), .FRAC_BITS(FRAC), .MAX_NODES(MAXN), .NL_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_num_nodes(cfg_num_nodes), .cfg_fb_shift(cfg_fb_shift),
        .din(din), .din_valid(din_valid), .din_ready(din_ready1),
        .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready),
        .dout_node(dout_node1), .dout_last(dout_last1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_node(input int d, input int p, input int sh, input bit nl);
        int s;
        s = d + (p >>> sh);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (nl) begin
            if (s > 256) s = 256;
            else if (s < -256) s = -256;
        end
        return s[W-1:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_n = MAXN; m_sh = 0; m_clr = 0; m_pos = 0;
        e_valid = 1'b0; e_last = 1'b0; e_node = 0;
        e_dout0 = '0; e_dout1 = '0;
    endtask

    // One clock: check handshake at negedge, advance model at posedge, check registers after it
    task automatic cycle();
        bit exp_rdy, old_valid;
        int d;
        @(negedge clk);
        exp_rdy = (m_mode == 2) && (!e_valid || dout_ready);
        obs_rdy = din_ready0;
        check_eq("din_ready", din_ready0, exp_rdy);
        check_eq("din_ready_nl", din_ready1, exp_rdy);
        check_eq("busy", busy0, m_mode != 0);
        check_eq("busy_nl", busy1, m_mode != 0);
        @(posedge clk);
        last_acc  = exp_rdy && din_valid;
        old_valid = e_valid;
        case (m_mode)
            0: if (start) begin
                   m_n   = (cfg_num_nodes == 0 || cfg_num_nodes > MAXN) ? MAXN : int'(cfg_num_nodes);
                   m_sh  = int'(cfg_fb_shift);
                   m_clr = m_n; m_pos = 0; m_mode = 1;
                   for (int i = 0; i < MAXN; i++) begin prev0[i] = 0; prev1[i] = 0; end
               end
            1: begin m_clr--; if (m_clr == 0) m_mode = 2; end
            2: if (stop) m_mode = 3;
            3: if (!old_valid) m_mode = 0;
            default: m_mode = 0;
        endcase
        if (last_acc) begin
            d = int'($signed(din));
            e_dout0 = ref_node(d, prev0[m_pos], m_sh, 1'b0);
            e_dout1 = ref_node(d, prev1[m_pos], m_sh, 1'b1);
            prev0[m_pos] = int'($signed(e_dout0));
            prev1[m_pos] = int'($signed(e_dout1));
            e_node  = m_pos;
            e_last  = (m_pos == m_n - 1);
            e_valid = 1'b1;
            m_pos   = (m_pos + 1) % m_n;
        end else if (dout_ready) begin
            e_valid = 1'b0;
        end
        #1;
        check_eq("dout_valid", dout_valid0, e_valid);
        check_eq("dout_valid_nl", dout_valid1, e_valid);
        check_eq("dout", dout0, e_dout0);
        check_eq("dout_nl", dout1, e_dout1);
        check_eq("dout_node", dout_node0, e_node);
        check_eq("dout_last", dout_last0, e_last);
        if (last_acc) begin
            cap0_q.push_back(dout0); cap1_q.push_back(dout1);
            capn_q.push_back(int'(dout_node0)); capl_q.push_back(dout_last0);
        end
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        rst = 1'b0;
        #1;
        check_eq("rst_dout", dout0, 0);
        check_eq("rst_dout_valid", dout_valid0, 0);
        check_eq("rst_dout_node", dout_node0, 0);
        check_eq("rst_dout_last", dout_last0, 0);
        check_eq("rst_din_ready", din_ready0, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_dout_valid_nl", dout_valid1, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Start a run and return how many cycles din_ready stayed low while clearing
    task automatic start_run(input int n, input int sh, output int clr);
        cfg_num_nodes = NW'(n); cfg_fb_shift = SW'(sh);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cfg_num_nodes = NW'($urandom); cfg_fb_shift = SW'($urandom);
        clr = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (obs_rdy) break;
            clr++;
        end
    endtask

    // Push every stim_q sample through; dout_ready is dropped for feed cycles [hold_lo, hold_hi)
    task automatic feed(input int hold_lo, input int hold_hi);
        int k, got;
        k = 0; got = 0;
        cap0_q.delete(); cap1_q.delete(); capn_q.delete(); capl_q.delete();
        while (got < stim_q.size() && k < 400) begin
            din = stim_q[got];
            din_valid = 1'b1;
            dout_ready = !(k >= hold_lo && k < hold_hi);
            cycle();
            if (last_acc) got++;
            k++;
        end
        din_valid = 1'b0; dout_ready = 1'b1;
        check_eq("feed_count", got, stim_q.size());
    endtask

    task automatic stop_and_drain();
        int k;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        k = 0;
        while (busy0 && k < 20) begin cycle(); k++; end
        check_eq("drain_idle", busy0, 1'b0);
    endtask

    task automatic fill(input int cnt, input logic [W-1:0] v);
        stim_q.delete();
        for (int i = 0; i < cnt; i++) stim_q.push_back(v);
    endtask

    initial begin
        int clr;
        logic [W-1:0] exp_v;
        rst = 1'b0; start = 1'b0; stop = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        din = '0; cfg_num_nodes = '0; cfg_fb_shift = '0;
        model_reset();
        do_reset();

        // T1: N=4, gain 1/2, constant 1.0 input
        start_run(4, 1, clr);
        check_eq("t1_clear_len", clr, 4);
        fill(12, 16'h0100);
        feed(-1, -1);
        for (int i = 0; i < 12 && i < cap0_q.size(); i++) begin
            exp_v = (i < 4) ? 16'h0100 : (i < 8) ? 16'h0180 : 16'h01C0;
            check_eq("t1_dout", cap0_q[i], exp_v);
            check_eq("t1_node", capn_q[i], i % 4);
            check_eq("t1_last", capl_q[i], (i % 4) == 3);
        end
        // T3 on the clamping instance, same traffic
        for (int i = 0; i < 12 && i < cap1_q.size(); i++) check_eq("t3_clamp_pos", cap1_q[i], 16'h0100);

        // T2: positive then negative saturation with unity gain
        do_reset();
        start_run(4, 0, clr);
        fill(8, 16'h7000);
        feed(-1, -1);
        for (int i = 0; i < cap0_q.size(); i++) check_eq("t2_pos", cap0_q[i], (i < 4) ? 16'h7000 : 16'h7FFF);
        stop_and_drain();
        start_run(4, 0, clr);
        fill(8, 16'h9000);
        feed(-1, -1);
        for (int i = 0; i < cap0_q.size(); i++) check_eq("t2_neg", cap0_q[i], (i < 4) ? 16'h9000 : 16'h8000);
        stop_and_drain();

        // T3: negative clamp to -1.0
        start_run(4, 1, clr);
        fill(4, 16'hFE00);
        feed(-1, -1);
        for (int i = 0; i < cap1_q.size(); i++) check_eq("t3_clamp_neg", cap1_q[i], 16'hFF00);

        // T4: backpressure mid-frame gives the T1 sequence unchanged
        do_reset();
        start_run(4, 1, clr);
        fill(12, 16'h0100);
        feed(5, 8);
        for (int i = 0; i < cap0_q.size(); i++)
            check_eq("t4_dout", cap0_q[i], (i < 4) ? 16'h0100 : (i < 8) ? 16'h0180 : 16'h01C0);

        // T5: stop, restart with cfg 0 (=> 8 nodes), feedback starts from zero
        do_reset();
        start_run(4, 1, clr);
        fill(6, 16'h0200);
        feed(-1, -1);
        stop_and_drain();
        start_run(0, 1, clr);
        check_eq("t5_clear_len", clr, 8);
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(W'($urandom_range(0, 16'h3FFF)));
        feed(-1, -1);
        for (int i = 0; i < cap0_q.size(); i++) begin
            check_eq("t5_first_frame", cap0_q[i], stim_q[i]);
            check_eq("t5_last", capl_q[i], i == 7);
        end

        // T6: asynchronous reset while an output is held
        din = 16'h0123; din_valid = 1'b1; dout_ready = 1'b0;
        cycle(); cycle(); cycle();
        check_eq("t6_pre_valid", dout_valid0, 1'b1);
        #2;
        do_reset();
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t6_no_ready", din_ready0, 1'b0);
        end
        din_valid = 1'b0;

        // Randomized traffic: random config, pulses, valid/ready and data
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end
            start         = ($urandom_range(0, 24) == 0);
            stop          = ($urandom_range(0, 79) == 0);
            cfg_num_nodes = NW'($urandom_range(0, 15));
            cfg_fb_shift  = SW'($urandom);
            din           = W'($urandom);
            din_valid     = ($urandom_range(0, 3) != 0);
            dout_ready    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        start = 1'b0; stop = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
